// File: rtl/cim_ctrl_pkg.sv
// Shared encodings and defaults for the compute-in-memory command sequencer.
package cim_ctrl_pkg;

    localparam int DEF_ACT_W  = 8;
    localparam int DEF_PSUM_W = 12;
    localparam int N_BANK     = 16;

    localparam logic OP_MAC    = 1'b0;
    localparam logic OP_SEARCH = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/cim_bitplane_sel.sv
// Picks bit-plane `plane` out of the 16 packed activations, one bit per bank.
module cim_bitplane_sel
    import cim_ctrl_pkg::*;
#(
    parameter int ACT_W = DEF_ACT_W,
    parameter int PW    = (ACT_W > 1) ? $clog2(ACT_W) : 1
) (
    input  logic [N_BANK*ACT_W-1:0] act,
    input  logic [PW-1:0]           plane,
    output logic [N_BANK-1:0]       bits
);

    for (genvar k = 0; k < N_BANK; k++) begin : g_bank
        logic [ACT_W-1:0] a;
        assign a       = act[k*ACT_W +: ACT_W];
        assign bits[k] = a[plane];
    end

endmodule

// File: rtl/cim_mac_seq.sv
// One-command-at-a-time sequencer: streams activation bit-planes to the array
// and shift-accumulates the returned partial sums into a single result.
module cim_mac_seq
    import cim_ctrl_pkg::*;
#(
    parameter int ACT_W  = DEF_ACT_W,
    parameter int PSUM_W = DEF_PSUM_W,
    parameter int ACC_W  = PSUM_W + ACT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_op,
    input  logic [N_BANK*ACT_W-1:0] cmd_act,
    input  logic [7:0]              cmd_col,
    output logic                    mac_en,
    output logic [7:0]              col_mux,
    output logic [N_BANK-1:0]       data_in,
    input  logic                    psum_vld,
    input  logic [PSUM_W-1:0]       psum,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_data,
    output logic                    res_op,
    output logic                    err
);

    localparam int CW = $clog2(ACT_W + 1);
    localparam int PW = (ACT_W > 1) ? $clog2(ACT_W) : 1;

    state_e                    state_q, state_d;
    logic                      op_q, op_d;
    logic [N_BANK*ACT_W-1:0]   act_q, act_d;
    logic [CW-1:0]             iss_q, iss_d;
    logic [CW-1:0]             ret_q, ret_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic                      mac_en_q, mac_en_d;
    logic [7:0]                col_mux_q, col_mux_d;
    logic [N_BANK-1:0]         data_in_q, data_in_d;
    logic                      res_valid_q, res_valid_d;
    logic                      err_q, err_d;

    logic [N_BANK*ACT_W-1:0]   sel_act;
    logic [PW-1:0]             sel_plane;
    logic [N_BANK-1:0]         plane_bits;
    logic [CW-1:0]             n_issue;
    logic                      hs;
    logic                      psum_take;

    assign cmd_ready = (state_q == ST_IDLE);
    assign hs        = cmd_valid && cmd_ready;
    assign n_issue   = (op_q == OP_SEARCH) ? CW'(1) : CW'(ACT_W);

    // Plane 0 must be registered on the accept edge, before act_q holds the command.
    assign sel_act   = (state_q == ST_IDLE) ? cmd_act : act_q;
    assign sel_plane = (state_q == ST_IDLE) ? '0 : PW'(iss_q);

    assign psum_take = psum_vld && (state_q == ST_ISSUE || state_q == ST_DRAIN)
                       && (ret_q < n_issue);

    cim_bitplane_sel #(.ACT_W(ACT_W), .PW(PW)) u_sel (
        .act   (sel_act),
        .plane (sel_plane),
        .bits  (plane_bits)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        act_d     = act_q;
        iss_d     = iss_q;
        ret_d     = ret_q;
        acc_d     = acc_q;
        mac_en_d  = 1'b0;
        col_mux_d = '0;
        data_in_d = '0;
        err_d     = err_q | (psum_vld && !psum_take);

        if (psum_take) begin
            ret_d = ret_q + CW'(1);
            acc_d = (op_q == OP_SEARCH) ? ACC_W'(psum)
                                        : acc_q + (ACC_W'(psum) << ret_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    op_d    = cmd_op;
                    act_d   = cmd_act;
                    acc_d   = '0;
                    ret_d   = '0;
                    iss_d   = CW'(1);
                    state_d = ST_ISSUE;
                    if (cmd_op == OP_SEARCH) begin
                        col_mux_d = cmd_col;
                    end else begin
                        mac_en_d  = 1'b1;
                        data_in_d = plane_bits;
                    end
                end
            end
            ST_ISSUE: begin
                if (iss_q < n_issue) begin
                    iss_d     = iss_q + CW'(1);
                    mac_en_d  = 1'b1;
                    data_in_d = plane_bits;
                end else begin
                    // A return landing on this same edge may already complete the set.
                    state_d = (ret_d == n_issue) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ret_d == n_issue) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        res_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MAC;
            act_q       <= '0;
            iss_q       <= '0;
            ret_q       <= '0;
            acc_q       <= '0;
            mac_en_q    <= 1'b0;
            col_mux_q   <= '0;
            data_in_q   <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            act_q       <= act_d;
            iss_q       <= iss_d;
            ret_q       <= ret_d;
            acc_q       <= acc_d;
            mac_en_q    <= mac_en_d;
            col_mux_q   <= col_mux_d;
            data_in_q   <= data_in_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    assign mac_en    = mac_en_q;
    assign col_mux   = col_mux_q;
    assign data_in   = data_in_q;
    assign res_valid = res_valid_q;
    assign res_data  = acc_q;
    assign res_op    = op_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cim_mac_seq.sv
// Scoreboard bench for cim_mac_seq with a latency-configurable adder-tree model.
module tb_cim_mac_seq;
    import cim_ctrl_pkg::*;

    localparam int ACT_W  = 8;
    localparam int PSUM_W = 12;
    localparam int ACC_W  = PSUM_W + ACT_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cmd_valid, cmd_ready, cmd_op;
    logic [N_BANK*ACT_W-1:0] cmd_act;
    logic [7:0]              cmd_col, col_mux;
    logic                    mac_en;
    logic [N_BANK-1:0]       data_in;
    logic                    psum_vld = 1'b0;
    logic [PSUM_W-1:0]       psum = '0;
    logic                    res_valid, res_ready, res_op, err;
    logic [ACC_W-1:0]        res_data;

    cim_mac_seq #(.ACT_W(ACT_W), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_act(cmd_act), .cmd_col(cmd_col),
        .mac_en(mac_en), .col_mux(col_mux), .data_in(data_in),
        .psum_vld(psum_vld), .psum(psum),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic op; longint data; } exp_t;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   th = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Adder tree: one strobe per driven plane, delayed by lat cycles.
    int   lat = 2;
    bit   force_en = 1'b0;
    int   force_val = 0;
    int   srch_val = 0;
    logic pv [0:2] = '{1'b0, 1'b0, 1'b0};
    int   pd [0:2] = '{0, 0, 0};
    always @(negedge clk) begin
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = (mac_en === 1'b1) || (col_mux != 8'h00);
        pd[0] = force_en ? force_val : ((mac_en === 1'b1) ? 2 * $countones(data_in) : srch_val);
        psum_vld = pv[lat];
        psum     = PSUM_W'(pd[lat]);
    end

    logic [N_BANK-1:0] plane_log[$];
    int                srch_n = 0;
    logic [7:0]        srch_col = '0;
    always @(negedge clk) begin
        if (mac_en === 1'b1) plane_log.push_back(data_in);
        if (mac_en === 1'b0 && col_mux != 8'h00) begin
            srch_n++;
            srch_col = col_mux;
        end
    end

    function automatic logic [N_BANK*ACT_W-1:0] fill(input logic [7:0] v);
        logic [N_BANK*ACT_W-1:0] r;
        for (int k = 0; k < N_BANK; k++) r[k*ACT_W +: ACT_W] = v;
        return r;
    endfunction

    function automatic logic [N_BANK*ACT_W-1:0] ramp();
        logic [N_BANK*ACT_W-1:0] r;
        for (int k = 0; k < N_BANK; k++) r[k*ACT_W +: ACT_W] = 8'(k);
        return r;
    endfunction

    // With every weight 2, the shift-accumulated planes sum to 2 * sum(activations).
    function automatic longint mac_ref(input logic [N_BANK*ACT_W-1:0] a, input bit fe, input int fv);
        longint s = 0;
        if (fe) for (int p = 0; p < ACT_W; p++) s += longint'(fv) << p;
        else    for (int k = 0; k < N_BANK; k++) s += 2 * longint'(a[k*ACT_W +: ACT_W]);
        return s;
    endfunction

    task automatic send(input logic op, input logic [N_BANK*ACT_W-1:0] act,
                        input logic [7:0] col, input longint exp);
        int n = 0;
        exp_t e;
        plane_log.delete();
        srch_n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_act = act; cmd_col = col;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        e.op = op; e.data = exp;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        th = cyc;
    endtask

    task automatic wait_valid(output int l);
        int n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        if (!res_valid) begin
            chk("res_valid_timeout", 0, 1);
            l = -1;
        end else begin
            l = cyc - th + 1;
        end
    endtask

    task automatic take_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_data"}, res_data, e.data);
        chk({tag, "_op"}, res_op, e.op);
        @(negedge clk);
        chk({tag, "_post_valid"}, res_valid, 0);
        chk({tag, "_post_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   l;
        int   seen;
        exp_t e;
        logic [N_BANK*ACT_W-1:0] a;

        cmd_valid = 1'b0; cmd_op = OP_MAC; cmd_act = '0; cmd_col = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_col_mux", col_mux, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_op", res_op, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // MAC basic, L=2
        lat = 2;
        a = fill(8'h03);
        send(OP_MAC, a, 8'h00, mac_ref(a, 0, 0));
        wait_valid(l);
        chk("mac_lat", l, 11);
        take_result("mac");
        chk("mac_nplanes", plane_log.size(), ACT_W);
        for (int p = 0; p < plane_log.size() && p < ACT_W; p++)
            chk("mac_plane", plane_log[p], (p < 2) ? 16'hFFFF : 16'h0000);

        // SEARCH
        srch_val = 5;
        send(OP_SEARCH, '0, 8'h04, 5);
        wait_valid(l);
        chk("srch_lat", l, 4);
        take_result("srch");
        chk("srch_cycles", srch_n, 1);
        chk("srch_col", srch_col, 8'h04);
        chk("srch_no_mac", plane_log.size(), 0);

        // Max MAC, forced psum
        force_en = 1'b1; force_val = 4080;
        a = fill(8'hFF);
        send(OP_MAC, a, 8'h00, mac_ref(a, 1, 4080));
        wait_valid(l);
        chk("max_lat", l, 11);
        take_result("max");
        force_en = 1'b0;

        // Backpressure on DONE with a queued SEARCH
        res_ready = 1'b0;
        a = ramp();
        send(OP_MAC, a, 8'h00, mac_ref(a, 0, 0));
        wait_valid(l);
        chk("bp_lat", l, 11);
        e = sb.pop_front();
        srch_val = 7;
        cmd_valid = 1'b1; cmd_op = OP_SEARCH; cmd_act = '0; cmd_col = 8'h08;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, e.data);
            chk("bp_op", res_op, e.op);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_no_issue", col_mux, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ready", cmd_ready, 1);
        chk("bp_rel_valid", res_valid, 0);
        e.op = OP_SEARCH; e.data = 7;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        th = cyc;
        chk("bp_next_col", col_mux, 8'h08);
        wait_valid(l);
        chk("bp_next_lat", l, 4);
        take_result("bp_next");

        // Zero latency: strobes overlap ISSUE, no DRAIN cycle
        lat = 0;
        a = fill(8'h03);
        send(OP_MAC, a, 8'h00, mac_ref(a, 0, 0));
        wait_valid(l);
        chk("l0_lat", l, ACT_W + 1);
        take_result("l0");
        chk("err_still_clear", err, 0);

        // Reset mid-ISSUE on plane 3; in-flight psums then arrive in IDLE
        lat = 2;
        send(OP_MAC, a, 8'h00, mac_ref(a, 0, 0));
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        chk("rst3_plane_on", mac_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst3_mac_en", mac_en, 0);
        chk("rst3_data_in", data_in, 0);
        chk("rst3_cmd_ready", cmd_ready, 1);
        chk("rst3_res_valid", res_valid, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("rst3_no_result", seen, 0);
        chk("rst3_err", err, 1);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cim_mac_seq.md
# cim_mac_seq

Command sequencer for the compute-in-memory array-and-logic stage. Accepts one MAC or SEARCH command at a time and drives the array stage's `mac_en`, `col_mux` and `data_in` inputs. For a MAC it streams unsigned activations bit-serially, one bit-plane per cycle, LSB first. It collects the per-plane partial sums returned by the downstream adder tree and shift-accumulates them into one result, delivered on a valid/ready port.

## Interface
Parameters:
- `ACT_W`, default 8: activation width, which is also the number of bit-planes per MAC.
- `PSUM_W`, default 12: width of the adder-tree partial sum (16 × 255 = 4080 fits in 12 bits).
- `ACC_W`, default `PSUM_W+ACT_W`: result width.

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on a cycle where `cmd_valid && cmd_ready`.
- `cmd_op` in 1: 0 = MAC, 1 = SEARCH.
- `cmd_act` in 16*ACT_W: activation k occupies `[k*ACT_W +: ACT_W]`. Unsigned.
- `cmd_col` in 8: column select mask for SEARCH.
- `mac_en` out 1: to array stage.
- `col_mux` out 8: to array stage.
- `data_in` out 16: to array stage; bit k = current bit-plane of activation k.
- `psum_vld` in 1: partial-sum strobe from adder tree.
- `psum` in PSUM_W: partial sum.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result accepted on a cycle where `res_valid && res_ready`.
- `res_data` out ACC_W: result value.
- `res_op` out 1: op of the returned result.
- `err` out 1: sticky flag, set by an unexpected `psum_vld`.

## Operation
States: IDLE, ISSUE, DRAIN, DONE.

- **IDLE**
  - `cmd_ready=1`.
  - On handshake: latch op, activations and column mask; clear the accumulator; clear the issue and return counters; go to ISSUE.
- **ISSUE**
  - Drive one plane per cycle.
  - MAC: `mac_en=1`, `col_mux=0`, `data_in[k]` = bit p of activation k, for p = 0..ACT_W-1.
  - SEARCH: `mac_en=0`, `col_mux=cmd_col`, `data_in=0` for exactly 1 cycle.
  - After the last plane, go to DRAIN. If all returns have already arrived, go directly to DONE.
- **DRAIN**
  - Wait until the return count equals the issue count (ACT_W for MAC, 1 for SEARCH), then go to DONE.
- **DONE**
  - `res_valid=1`; `res_data` and `res_op` are held stable.
  - On `res_ready`, go to IDLE.

Accumulation:
- `psum_vld` is honoured in ISSUE and DRAIN, which covers adder-tree latencies shorter than ACT_W.
- MAC: the j-th returned psum (j from 0) adds `psum << j` to the accumulator.
- SEARCH: the accumulator takes `psum` directly (the downstream match count).
- Arithmetic is unsigned and cannot overflow ACC_W with the default parameters.

Outside ISSUE, `mac_en=0`, `col_mux=0` and `data_in=0`.

`err` behaviour:
- `psum_vld` in IDLE or DONE, or once the return count has reached the issue count, is ignored and sets `err`.
- `err` clears only on `rst`.

Reset values: state IDLE, `cmd_ready=1`, `mac_en=0`, `col_mux=0`, `data_in=0`, `res_valid=0`, `res_data=0`, `res_op=0`, `err=0`.

Reset mid-operation aborts the command with no result. Late psums that arrive after the reset set `err`.

## Timing
- All outputs are registered, except `cmd_ready`, which is decoded from the state register.
- Handshake at edge t:
  - Plane 0 is on the outputs in cycle t+1.
  - The MAC's last plane is in cycle t+ACT_W.
  - The SEARCH plane is in cycle t+1 only.
- `res_valid` rises in the cycle after the edge that captured the final `psum_vld`.
- With adder-tree latency L (strobe L cycles after each plane), MAC `res_valid` appears at t+ACT_W+L+1.
- `cmd_ready` stays low from acceptance until the cycle after the result handshake. Only one command is in flight.
- `res_valid` may not drop without `res_ready`.
- `psum_vld` on the same cycle as a state transition is still accumulated if it is within the expected count.

## Structure
- Package `cim_ctrl_pkg` holds:
  - the op encoding (`OP_MAC=0`, `OP_SEARCH=1`);
  - the state enum;
  - default ACT_W and PSUM_W, and `N_BANK=16`.
- One sub-module, `cim_bitplane_sel`: combinational extraction of plane p from the 16 latched activations into 16 bits.
- Counters, FSM and accumulator live in `cim_mac_seq`.

## Test plan
Bench adder model: `psum = 2*popcount(data_in)` (all weights 2) for MAC, and a programmed value for SEARCH, both with latency L=2.

- **MAC basic:** all 16 activations 0x03, L=2.
  - Planes 0 and 1 show `data_in=0xFFFF`; planes 2..7 show 0.
  - `res_data=96`, `res_op=0`, `res_valid` at t+11.
- **SEARCH:** `cmd_col=0x04`, model returns psum=5.
  - `col_mux=0x04` with `mac_en=0` for exactly one cycle.
  - `res_data=5`, `res_op=1`.
- **Max MAC:** all activations 0xFF, model forced to psum=4080 per plane.
  - `res_data=1040400`, no wrap.
- **Backpressure:** hold `res_ready=0` for 3 cycles in DONE.
  - `res_data` stable, `cmd_ready=0`, a new `cmd_valid` is not accepted.
  - After release, the next command is accepted one cycle later.
- **Reset mid-ISSUE:** assert `rst` on plane 3.
  - Next cycle: `mac_en=0`, `data_in=0`, `cmd_ready=1`, `res_valid=0`.
  - A stray late `psum_vld` sets `err=1` and no result is produced.
- **Zero-latency-overlap:** L=0, with strobes concurrent with ISSUE.
  - The result matches the MAC basic value (96).
  - `res_valid` asserts at t+ACT_W+1 with no DRAIN cycle.
